// File: rtl/spi_ctrl_pkg.sv
// Shared types, default widths and bit-order helpers for the SPI transfer sequencer.
// Bit order is set at build time by SPI_LSB_FIRST_EN; MSB-first when it is undefined.
package spi_ctrl_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    // Bit presented on mosi for the current transmit shift-register contents.
    function automatic logic first_bit(input logic [7:0] b);
        return LSB_FIRST ? b[0] : b[7];
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] b);
        return LSB_FIRST ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
    endfunction

    // The first received bit ends up in bit 7 (MSB-first) or bit 0 (LSB-first).
    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_in);
        return LSB_FIRST ? {bit_in, b[7:1]} : {b[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host-side byte handshake of the SPI transfer sequencer; master = host logic,
// slave = spi_xfer_ctrl.
interface spi_xfer_ctrl_if
    import spi_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] nbytes;
    logic [7:0]       tx_data;
    logic             tx_ack;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, div, nbytes, tx_data,
        input  tx_ack, rx_data, rx_valid, busy, done
    );

    modport slave (
        input  start, div, nbytes, tx_data,
        output tx_ack, rx_data, rx_valid, busy, done
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, idle-low sclk register and edge strobes.
// tick/rise/fall are high in the cycle before the edge they announce.
module spi_sclk_gen
    import spi_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             toggle_en,
    input  logic [DIV_W-1:0] div,
    output logic             sclk,
    output logic             tick,
    output logic             rise,
    output logic             fall
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        tick   = en && (cnt_q == div);
        rise   = tick && toggle_en && !sclk_q;
        fall   = tick && toggle_en && sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            if (toggle_en) sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Mode-0 SPI master transfer sequencer: CS framing, byte handshake, MOSI/MISO shifting.
// Define SPI_LSB_FIRST_EN for LSB-first bit order (see spi_ctrl_pkg).
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    spi_xfer_ctrl_if.slave  host,
    output logic            sclk,
    output logic            cs_n,
    output logic            mosi,
    input  logic            miso
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bytes_q, bytes_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_ack_q, tx_ack_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             samp_q, samp_d;

    logic accept;
    logic tick, rise, fall;

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q != ST_IDLE),
        .toggle_en (state_q == ST_SHIFT),
        .div       (div_q),
        .sclk      (sclk),
        .tick      (tick),
        .rise      (rise),
        .fall      (fall)
    );

    // Blocking acceptance in the done cycle guarantees cs_n stays high between transfers.
    assign accept = (state_q == ST_IDLE) && host.start && (host.nbytes != '0) && !done_q && !rst;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bytes_d    = bytes_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        cs_n_d     = cs_n_q;
        // MISO is captured one cycle after the rising edge, while sclk is high, so a
        // byte reloaded on a back-to-back boundary is already on mosi at div=0.
        samp_d     = rise;
        rx_sh_d    = samp_q ? shift_in(rx_sh_q, miso) : rx_sh_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    div_d   = host.div;
                    bytes_d = host.nbytes;
                    tx_sh_d = host.tx_data;
                    bit_d   = 3'd0;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tx_ack_q) tx_sh_d = host.tx_data;
                if (fall) begin
                    if (bit_q == 3'd7) begin
                        rx_data_d  = rx_sh_d;
                        rx_valid_d = 1'b1;
                        bit_d      = 3'd0;
                        if (bytes_q == CNT_W'(1)) begin
                            state_d = ST_HOLD;
                        end else begin
                            bytes_d  = bytes_q - 1'b1;
                            tx_ack_d = 1'b1;
                        end
                    end else begin
                        tx_sh_d = shift_out(tx_sh_q);
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mosi_d = first_bit(tx_sh_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bytes_q    <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            samp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bytes_q    <= bytes_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            samp_q     <= samp_d;
        end
    end

    assign host.tx_ack   = tx_ack_q | accept;
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign cs_n          = cs_n_q;
    assign mosi          = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: cycle-exact handshake, framing and data checks
// in both bit-order builds (SPI_LSB_FIRST_EN).
module tb_spi_xfer_ctrl;

`ifdef SPI_LSB_FIRST_EN
    localparam bit TB_LSB = 1'b1;
`else
    localparam bit TB_LSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk, cs_n, mosi, miso;
    bit   loopback;
    logic miso_lvl;

    spi_xfer_ctrl_if #(.DIV_W(8), .CNT_W(4)) bus ();

    spi_xfer_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus.slave),
        .sclk (sclk),
        .cs_n (cs_n),
        .mosi (mosi),
        .miso (miso)
    );

    assign miso = loopback ? mosi : miso_lvl;

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          ack_cyc[$];
    int          rxv_cyc[$];
    int          rxv_dat[$];
    int          done_cyc[$];
    int          tog_cyc[$];
    int          toggles, busy_cnt, cs_first, cs_last;
    logic [31:0] mosi_seq;
    logic        sclk_prev;
    logic        csn_hist  [512];
    logic        sclk_hist [512];
    logic        busy_hist [512];
    logic        mosi_hist [512];

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        ack_cyc.delete();
        rxv_cyc.delete();
        rxv_dat.delete();
        done_cyc.delete();
        tog_cyc.delete();
        toggles   = 0;
        busy_cnt  = 0;
        cs_first  = -1;
        cs_last   = -1;
        mosi_seq  = '0;
        sclk_prev = sclk;
    endtask

    // Called at the negative edge of cycle rel (rel 0 = cycle start is presented).
    task automatic record(input int rel);
        if (bus.tx_ack === 1'b1) ack_cyc.push_back(rel);
        if (bus.rx_valid === 1'b1) begin
            rxv_cyc.push_back(rel);
            rxv_dat.push_back(int'(bus.rx_data));
        end
        if (bus.done === 1'b1) done_cyc.push_back(rel);
        if (bus.busy === 1'b1) busy_cnt++;
        if (sclk !== sclk_prev) begin
            toggles++;
            tog_cyc.push_back(rel);
            if (sclk === 1'b1) mosi_seq = {mosi_seq[30:0], mosi};
        end
        sclk_prev = sclk;
        if (cs_n === 1'b0) begin
            if (cs_first < 0) cs_first = rel;
            cs_last = rel;
        end
        if (rel < 512) begin
            csn_hist[rel]  = cs_n;
            sclk_hist[rel] = sclk;
            busy_hist[rel] = bus.busy;
            mosi_hist[rel] = mosi;
        end
    endtask

    // One transfer: start presented in cycle 0, host supplies the next byte after each tx_ack.
    task automatic run_xfer(input int d, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input bit hold, input int ncyc, input int rst_at);
        logic [7:0] bytes [3];
        int         idx;
        logic       ack_prev;
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        clear_log();
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.div     = d[7:0];
        bus.nbytes  = n[3:0];
        bus.tx_data = b0;
        idx = 1;
        @(negedge clk);
        record(0);
        ack_prev = bus.tx_ack;
        for (int r = 1; r <= ncyc; r++) begin
            @(posedge clk);
            #1;
            if (!hold) bus.start = 1'b0;
            rst = (r == rst_at);
            if (ack_prev === 1'b1 && idx < 3) begin
                bus.tx_data = bytes[idx];
                idx++;
            end
            @(negedge clk);
            record(r);
            ack_prev = bus.tx_ack;
        end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.start   = 1'b0;
        bus.div     = '0;
        bus.nbytes  = '0;
        bus.tx_data = '0;
        loopback    = 1'b0;
        miso_lvl    = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_tx_ack", bus.tx_ack, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_sclk", sclk, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_mosi", mosi, 0);

        // div=0, one byte, loopback
        loopback = 1'b1;
        run_xfer(0, 1, 8'hA5, 8'h00, 8'h00, 1'b0, 25, -1);
        chk("t1_ack_n", ack_cyc.size(), 1);
        chk("t1_ack0", q_at(ack_cyc, 0), 0);
        chk("t1_cs_first", cs_first, 1);
        chk("t1_cs_last", cs_last, 17);
        chk("t1_mosi_c1", mosi_hist[1], 1);
        chk("t1_toggles", toggles, 16);
        chk("t1_tog_first", q_at(tog_cyc, 0), 2);
        chk("t1_rxv_n", rxv_cyc.size(), 1);
        chk("t1_rxv_cyc", q_at(rxv_cyc, 0), 17);
        chk("t1_rx_data", q_at(rxv_dat, 0), 8'hA5);
        chk("t1_done_n", done_cyc.size(), 1);
        chk("t1_done_cyc", q_at(done_cyc, 0), 18);
        chk("t1_busy_cycles", busy_cnt, 17);

        // div=3, three bytes, miso tied high
        loopback = 1'b0;
        miso_lvl = 1'b1;
        run_xfer(3, 3, 8'h01, 8'h80, 8'hFF, 1'b0, 205, -1);
        chk("t2_ack_n", ack_cyc.size(), 3);
        chk("t2_ack0", q_at(ack_cyc, 0), 0);
        chk("t2_ack1", q_at(ack_cyc, 1), 65);
        chk("t2_ack2", q_at(ack_cyc, 2), 129);
        chk("t2_rxv_n", rxv_cyc.size(), 3);
        chk("t2_rxv0", q_at(rxv_cyc, 0), 65);
        chk("t2_rxv1", q_at(rxv_cyc, 1), 129);
        chk("t2_rxv2", q_at(rxv_cyc, 2), 193);
        chk("t2_rxd0", q_at(rxv_dat, 0), 8'hFF);
        chk("t2_rxd2", q_at(rxv_dat, 2), 8'hFF);
        chk("t2_done_cyc", q_at(done_cyc, 0), 197);
        chk("t2_toggles", toggles, 48);
        chk("t2_tog_first", q_at(tog_cyc, 0), 5);
        chk("t2_period", q_at(tog_cyc, 2) - q_at(tog_cyc, 0), 8);
        chk("t2_mosi_bits", mosi_seq[23:0], TB_LSB ? 24'h8001FF : 24'h0180FF);
        chk("t2_cs_last", cs_last, 196);

        // nbytes=0 is ignored
        miso_lvl = 1'b0;
        run_xfer(3, 0, 8'h5A, 8'h00, 8'h00, 1'b1, 20, -1);
        chk("t3_ack_n", ack_cyc.size(), 0);
        chk("t3_busy_cycles", busy_cnt, 0);
        chk("t3_cs_first", cs_first, -1);
        chk("t3_done_n", done_cyc.size(), 0);

        // start held high through a div=1, two-byte transfer
        run_xfer(1, 2, 8'hC3, 8'h3C, 8'h00, 1'b1, 70, -1);
        chk("t4_ack_n", ack_cyc.size(), 3);
        chk("t4_ack1", q_at(ack_cyc, 1), 33);
        chk("t4_ack_restart", q_at(ack_cyc, 2), 68);
        chk("t4_rxv1", q_at(rxv_cyc, 1), 65);
        chk("t4_done_n", done_cyc.size(), 1);
        chk("t4_done_cyc", q_at(done_cyc, 0), 67);
        chk("t4_cs_c66", csn_hist[66], 0);
        chk("t4_cs_c67", csn_hist[67], 1);
        chk("t4_cs_c68", csn_hist[68], 1);
        chk("t4_busy_c68", busy_hist[68], 0);
        chk("t4_cs_c69", csn_hist[69], 0);
        pulse_reset();
        chk("t4_abort_cs_n", cs_n, 1);
        chk("t4_abort_busy", bus.busy, 0);

        // reset in cycle 10 of a div=2 transfer
        run_xfer(2, 1, 8'h55, 8'h00, 8'h00, 1'b0, 20, 10);
        chk("t5_sclk_c10", sclk_hist[10], 1);
        chk("t5_cs_c10", csn_hist[10], 0);
        chk("t5_cs_c11", csn_hist[11], 1);
        chk("t5_sclk_c11", sclk_hist[11], 0);
        chk("t5_busy_c11", busy_hist[11], 0);
        chk("t5_done_n", done_cyc.size(), 0);
        chk("t5_rxv_n", rxv_cyc.size(), 0);
        loopback = 1'b1;
        run_xfer(0, 1, 8'h3C, 8'h00, 8'h00, 1'b0, 25, -1);
        chk("t5b_rx_data", q_at(rxv_dat, 0), 8'h3C);
        chk("t5b_done_cyc", q_at(done_cyc, 0), 18);

        // bit order with a single set bit, loopback
        run_xfer(0, 1, 8'h01, 8'h00, 8'h00, 1'b0, 25, -1);
        chk("t6_mosi_c1", mosi_hist[1], TB_LSB ? 1 : 0);
        chk("t6_mosi_bits", mosi_seq[7:0], TB_LSB ? 8'h80 : 8'h01);
        chk("t6_rx_data", q_at(rxv_dat, 0), 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
